// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters write access to one shared register.
// Optional feature: define ARB_LOCK_EN to let a grantee hold the register through a LOCKED state.
module rr_reg_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_W-1:0]     wr_data,
    input  logic [NUM_REQ-1:0]            lock,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [DATA_W-1:0]             q,
    output logic                          q_valid,
    output logic [$clog2(NUM_REQ)-1:0]    last_id,
    output logic [7:0]                    grant_cnt
);

    localparam int ID_W = $clog2(NUM_REQ);

`ifdef ARB_LOCK_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } state_e;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;
`endif

    state_e                state_q, state_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [ID_W-1:0]       cur_q, cur_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  valid_q, valid_d;
    logic [ID_W-1:0]       last_id_q, last_id_d;
    logic [7:0]            cnt_q, cnt_d;

    logic [NUM_REQ-1:0]    search_req;
    logic [ID_W-1:0]       search_start;
    logic [ID_W-1:0]       scan_idx;
    logic                  pick_found;
    logic [ID_W-1:0]       pick_idx;
    logic                  hold_lock;
    logic [DATA_W-1:0]     cur_lane;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx);
        if (int'(idx) == NUM_REQ - 1) begin
            return '0;
        end
        return idx + ID_W'(1);
    endfunction

`ifdef ARB_LOCK_EN
    assign hold_lock = lock[cur_q];
`else
    logic unused_lock;
    assign hold_lock   = 1'b0;
    assign unused_lock = ^lock;
`endif

    assign cur_lane = wr_data[int'(cur_q)*DATA_W +: DATA_W];

    // The grantee still holds req at its own grant edge, so it is masked out of the
    // search; the search then starts just past it, which is where ptr is heading.
    assign search_req   = req & ~gnt_q;
    assign search_start = (state_q == IDLE) ? ptr_q : wrap_inc(cur_q);

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = search_start;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_found && search_req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
            scan_idx = wrap_inc(scan_idx);
        end
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        gnt_d     = '0;
        cur_d     = cur_q;
        ptr_d     = ptr_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_id_d = last_id_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d         = GRANT;
                    cur_d           = pick_idx;
                    gnt_d[pick_idx] = 1'b1;
                end
            end

            default: begin
                // Every edge with gnt high writes the grantee's lane.
                data_d    = cur_lane;
                valid_d   = 1'b1;
                last_id_d = cur_q;
                if (hold_lock) begin
`ifdef ARB_LOCK_EN
                    state_d = LOCKED;
`endif
                    gnt_d   = gnt_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    ptr_d = wrap_inc(cur_q);
                    if (pick_found) begin
                        state_d         = GRANT;
                        cur_d           = pick_idx;
                        gnt_d[pick_idx] = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            cur_q     <= '0;
            ptr_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_id_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            cur_q     <= cur_d;
            ptr_q     <= ptr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_id_q <= last_id_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign q         = data_q;
    assign q_valid   = valid_q;
    assign last_id   = last_id_q;
    assign grant_cnt = cnt_q;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(gnt_q));

    a_gnt_matches_state: assert property (@(posedge clk) disable iff (!reset_n)
        (state_q == IDLE) == (gnt_q == '0));

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Self-checking bench for rr_reg_arbiter: directed scenarios plus randomized traffic
// compared against an integer-level round-robin reference model.
module tb_rr_reg_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
`ifdef ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic                 clk     = 1'b0;
    logic                 reset_n = 1'b0;
    logic [N-1:0]         req     = '0;
    logic [N-1:0]         lock    = '0;
    logic [N*DW-1:0]      wr_data = '0;
    logic [N-1:0]         gnt;
    logic [DW-1:0]        q;
    logic                 q_valid;
    logic [$clog2(N)-1:0] last_id;
    logic [7:0]           grant_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: m_cur is the requester holding gnt (-1 when none).
    int            m_cur;
    int            m_ptr;
    int            m_last;
    int            m_cnt;
    logic [DW-1:0] m_q;
    logic          m_valid;

    rr_reg_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .wr_data   (wr_data),
        .lock      (lock),
        .gnt       (gnt),
        .q         (q),
        .q_valid   (q_valid),
        .last_id   (last_id),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_gnt();
        logic [N-1:0] g;
        g = '0;
        if (m_cur >= 0) g[m_cur] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_cur   = -1;
        m_ptr   = 0;
        m_last  = 0;
        m_cnt   = 0;
        m_q     = '0;
        m_valid = 1'b0;
    endtask

    task automatic model_edge();
        logic [N-1:0] others;
        if (m_cur < 0) begin
            m_cur = pick(req, m_ptr);
        end else begin
            m_q     = wr_data[m_cur*DW +: DW];
            m_valid = 1'b1;
            m_last  = m_cur;
            if (!(LOCK_EN && lock[m_cur])) begin
                m_cnt          = (m_cnt + 1) % 256;
                m_ptr          = (m_cur + 1) % N;
                others         = req;
                others[m_cur]  = 1'b0;
                m_cur          = pick(others, m_ptr);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_lane(input int i, input logic [DW-1:0] v);
        wr_data[i*DW +: DW] = v;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req     = '0;
        lock    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({gnt, q, q_valid, last_id, grant_cnt} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: gnt=%b q=%h q_valid=%b last_id=%0d grant_cnt=%0d, want all zero",
                     gnt, q, q_valid, last_id, grant_cnt);
        end
    endtask

    task automatic test_single();
        set_lane(0, 8'hA5);
        req = 4'b0001;
        tick();
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_gnt: got %b want 0001", gnt);
        end
        tick();
        req = '0;
        vectors++;
        if (gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_pulse: got %b want 0000", gnt);
        end
        vectors++;
        if (q !== 8'hA5 || q_valid !== 1'b1 || last_id !== 2'd0 || grant_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL single_write: q=%h q_valid=%b last_id=%0d grant_cnt=%0d, want a5 1 0 1",
                     q, q_valid, last_id, grant_cnt);
        end
        tick();
        vectors++;
        if (gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_no_regrant: got %b want 0000", gnt);
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_g;
        apply_reset();
        for (int i = 0; i < N; i++) set_lane(i, 8'(8'h10 + i));
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_g = 4'b0001 << (k % N);
            vectors++;
            if (gnt !== exp_g) begin
                miscompares++;
                $display("FAIL fair_gnt[%0d]: got %b want %b", k, gnt, exp_g);
            end
            if (k > 0) begin
                vectors++;
                if (q !== 8'(8'h10 + (k - 1) % N)) begin
                    miscompares++;
                    $display("FAIL fair_q[%0d]: got %h want %h", k, q, 8'(8'h10 + (k - 1) % N));
                end
            end
            if (k == 7) req = '0;
        end
        tick();
        vectors++;
        if (gnt !== 4'b0000 || grant_cnt !== 8'd8 || q !== 8'h13 || last_id !== 2'd3) begin
            miscompares++;
            $display("FAIL fair_end: gnt=%b grant_cnt=%0d q=%h last_id=%0d, want 0000 8 13 3",
                     gnt, grant_cnt, q, last_id);
        end
    endtask

    task automatic test_rotation();
        req = 4'b0100;
        tick();
        vectors++;
        if (gnt !== 4'b0100) begin
            miscompares++;
            $display("FAIL rot_first: got %b want 0100", gnt);
        end
        req = '0;
        tick();
        req = 4'b0101;
        tick();
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL rot_wrap: got %b want 0001", gnt);
        end
        tick();
        req = 4'b0100;
        vectors++;
        if (gnt !== 4'b0100) begin
            miscompares++;
            $display("FAIL rot_next: got %b want 0100", gnt);
        end
        tick();
        req = '0;
        vectors++;
        if (gnt !== 4'b0000 || last_id !== 2'd2) begin
            miscompares++;
            $display("FAIL rot_end: gnt=%b last_id=%0d, want 0000 2", gnt, last_id);
        end
    endtask

    task automatic test_wrap();
        int idx;
        apply_reset();
        for (int i = 1; i <= 256; i++) begin
            idx = int'($urandom_range(0, N - 1));
            set_lane(idx, DW'($urandom));
            req = 4'b0001 << idx;
            tick();
            req = '0;
            tick();
            vectors++;
            if (last_id !== idx[1:0]) begin
                miscompares++;
                $display("FAIL wrap_last_id[%0d]: got %0d want %0d", i, last_id, idx);
            end
            if (i == 255) begin
                vectors++;
                if (grant_cnt !== 8'd255) begin
                    miscompares++;
                    $display("FAIL wrap_255: got %0d want 255", grant_cnt);
                end
            end
            if (i == 256) begin
                vectors++;
                if (grant_cnt !== 8'd0 || q_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL wrap_0: grant_cnt=%0d q_valid=%b, want 0 1", grant_cnt, q_valid);
                end
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        set_lane(1, 8'h3C);
        req = 4'b0010;
        tick();
        req = '0;
        tick();
        req = 4'b0100;
        tick();
        vectors++;
        if (gnt !== 4'b0100) begin
            miscompares++;
            $display("FAIL midrst_setup: got %b want 0100", gnt);
        end
        #1;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({gnt, q, q_valid, last_id, grant_cnt} !== '0) begin
            miscompares++;
            $display("FAIL midrst_async: gnt=%b q=%h q_valid=%b last_id=%0d grant_cnt=%0d, want all zero",
                     gnt, q, q_valid, last_id, grant_cnt);
        end
        model_reset();
        req = '0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        req = 4'b1010;
        tick();
        vectors++;
        if (gnt !== 4'b0010) begin
            miscompares++;
            $display("FAIL midrst_ptr0: got %b want 0010", gnt);
        end
        req = '0;
        tick();
        vectors++;
        if (gnt !== 4'b0000 || grant_cnt !== 8'd1 || q !== 8'h3C) begin
            miscompares++;
            $display("FAIL midrst_after: gnt=%b grant_cnt=%0d q=%h, want 0000 1 3c", gnt, grant_cnt, q);
        end
    endtask

    task automatic test_lock();
        int            exp_len;
        int            exp_cnt;
        logic [N-1:0]  exp_g;
        logic [DW-1:0] lane_v;
        logic [DW-1:0] prev_q;
        apply_reset();
        exp_len = LOCK_EN ? 6 : 1;
        prev_q  = '0;
        set_lane(1, 8'h55);
        req = 4'b0010;
        tick();
        req  = '0;
        lock = 4'b0010;
        for (int c = 1; c <= 6; c++) begin
            lane_v = DW'($urandom);
            set_lane(1, lane_v);
            if (c == 6) lock = '0;
            exp_g = (c <= exp_len) ? 4'b0010 : 4'b0000;
            vectors++;
            if (gnt !== exp_g) begin
                miscompares++;
                $display("FAIL lock_gnt[%0d]: got %b want %b", c, gnt, exp_g);
            end
            if (c <= exp_len) prev_q = lane_v;
            tick();
            exp_cnt = (LOCK_EN && c < 6) ? 0 : 1;
            vectors++;
            if (q !== prev_q || grant_cnt !== 8'(exp_cnt)) begin
                miscompares++;
                $display("FAIL lock_write[%0d]: q=%h grant_cnt=%0d, want %h %0d",
                         c, q, grant_cnt, prev_q, exp_cnt);
            end
        end
        vectors++;
        if (gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL lock_exit: got %b want 0000", gnt);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            vectors++;
            if (gnt !== m_gnt() || q !== m_q || q_valid !== m_valid ||
                last_id !== 2'(m_last) || grant_cnt !== 8'(m_cnt)) begin
                miscompares++;
                $display("FAIL random[%0d]: gnt=%b q=%h v=%b id=%0d cnt=%0d, want %b %h %b %0d %0d",
                         cyc, gnt, q, q_valid, last_id, grant_cnt,
                         m_gnt(), m_q, m_valid, m_last, m_cnt);
            end
            for (int i = 0; i < N; i++) begin
                if (gnt[i])      req[i] = ($urandom_range(0, 99) < 50);
                else if (req[i]) req[i] = ($urandom_range(0, 99) < 90);
                else             req[i] = ($urandom_range(0, 99) < 30);
                if (lock[i])     lock[i] = ($urandom_range(0, 99) < 70);
                else             lock[i] = ($urandom_range(0, 99) < 20);
            end
            wr_data = {$urandom};
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_fairness();
        test_rotation();
        test_wrap();
        test_reset_mid_grant();
        test_lock();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_reg_arbiter.md
RR_REG_ARBITER -- requirements
Module: rr_reg_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the register; legal range 2..8.
REQ-002 Parameter DATA_W, default 8: width of the shared register and of each write-data lane.
REQ-003 Port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port req, input, NUM_REQ: per-requester write request, held high until the matching gnt bit is seen.
REQ-006 Port wr_data, input, NUM_REQ*DATA_W: lane i is bits [i*DATA_W +: DATA_W], valid while req[i] is high.
REQ-007 Port gnt, output, NUM_REQ: registered grant, one-hot or zero.
REQ-008 Port q, output, DATA_W: shared register contents.
REQ-009 Port q_valid, output, 1: sticky; high once q has been written since reset.
REQ-010 Port last_id, output, clog2(NUM_REQ): index of the most recent writer.
REQ-011 Port grant_cnt, output, 8: count of completed writes, wrapping 255 -> 0.
REQ-012 Port lock, input, NUM_REQ: per-requester hold request; used only when ARB_LOCK_EN is defined.

Function
REQ-013 The FSM SHALL have states IDLE and GRANT, plus LOCKED when ARB_LOCK_EN is defined.
REQ-014 IDLE: req == 0 -> stay in IDLE with gnt = 0; any req bit high -> go to GRANT and set gnt to the arbitration winner at the same edge.
REQ-015 Arbitration SHALL be round-robin: search starts at pointer ptr and ascends modulo NUM_REQ; the first set bit wins.
REQ-016 Latency: req[i] first high in cycle N with no competition -> gnt[i] high in cycle N+1.
REQ-017 At each edge where gnt[i] is high, the block SHALL set q <= lane i, last_id <= i, q_valid <= 1, grant_cnt <= grant_cnt + 1, and ptr <= (i+1) mod NUM_REQ.
REQ-018 gnt SHALL be a single-cycle pulse per write unless the grant is extended by LOCKED.
REQ-019 GRANT, arbitration: the current grantee's req bit SHALL be masked, because it is still high at the grant edge.
REQ-020 GRANT, exits: any other req bit high -> stay in GRANT with the new winner (back-to-back, no bubble); otherwise -> IDLE with gnt = 0.
REQ-021 A requester holding req after its own grant SHALL be re-granted at the earliest one IDLE cycle later; others are served first if pending.
REQ-022 Dropping req[i] before gnt[i] SHALL withdraw the request with no write.
REQ-023 When all NUM_REQ requesters request continuously, each SHALL receive exactly one grant per NUM_REQ consecutive grants.
REQ-024 grant_cnt SHALL wrap from 255 to 0 without any flag.

Reset
REQ-025 While reset_n is low, the block SHALL force state = IDLE, gnt = 0, q = 0, q_valid = 0, last_id = 0, grant_cnt = 0, ptr = 0, immediately and independent of clk.
REQ-026 Reset asserted during GRANT or LOCKED SHALL abort the write in progress; q shows 0 and no partial update remains.
REQ-027 First edge after reset_n rises: the block SHALL behave as IDLE, evaluating req with ptr = 0.

Configuration
REQ-028 Macro ARB_LOCK_EN defined: GRANT with lock[i] high for grantee i -> LOCKED.
REQ-029 LOCKED: gnt[i] stays high; q is rewritten from lane i every cycle; grant_cnt and ptr do not change.
REQ-030 LOCKED exit: when lock[i] falls, the block SHALL complete one final write, advance ptr and grant_cnt once, then follow the GRANT exit rules.
REQ-031 Macro ARB_LOCK_EN undefined: the lock port SHALL remain present but be ignored, and the LOCKED state SHALL NOT exist.

Verification
REQ-032 Reset check: reset_n low mid-GRANT -> gnt = 0, q = 0, q_valid = 0, grant_cnt = 0 within the same cycle, with no clk edge needed.
REQ-033 Single request: req = 0001, lane0 = 0xA5 -> gnt = 0001 one cycle later for one cycle; then q = 0xA5, q_valid = 1, last_id = 0, grant_cnt = 1.
REQ-034 Fairness: req = 1111 held for 8 grants with lanes 0x10..0x13 -> gnt order 0,1,2,3,0,1,2,3 with no idle cycles; grant_cnt = 8.
REQ-035 Pointer rotation: after grant to requester 2, req = 0101 -> gnt = 0001 first, then gnt = 0100.
REQ-036 Counter wrap: 256 single writes -> grant_cnt reads 0.
REQ-037 Lock (ARB_LOCK_EN defined): req = 0010 with lock = 0010 held 5 cycles -> gnt = 0010 for 6 cycles; q tracks lane 1 each cycle; grant_cnt increments by 1 only.
